pyrm_decode_sb: RTL and testbench
=================================

Name: pyrm_decode_sb

Overview:
- Parametrised next-generation RISC-V decode/register-read stage.
- Internal register file, busy-bit scoreboard, NWB write-back ports with optional same-cycle forwarding.
- Registered output stage with valid/retry handshake (one-cycle latency).
- Sits between fetch and execute; write-back ports are driven by the execute/memory stages.

Parameters:
- XLEN, 64, data/pc width.
- NREG, 32, architectural register count (power of 2); RA=log2(NREG) address bits.
- NWB, 2, number of write-back ports.

Ports:
- clk  in  1  clock.
- reset_pyri  in  1  asynchronous, active-low reset.
- inst_pyri  in  32  instruction.
- pc_pyri  in  XLEN  instruction pc.
- inst_valid_pyri  in  1  instruction/pc present.
- inst_retry_pyro  out  1  stall upstream.
- wb_valid_pyri  in  NWB  per-port write enable.
- wb_addr_pyri  in  NWB*RA  write-back destinations, port k at [k*RA +: RA].
- wb_data_pyri  in  NWB*XLEN  write-back data.
- inst_pyro  out  32  registered instruction.
- pc_pyro  out  XLEN  registered pc.
- src1_pyro  out  XLEN  operand 1.
- src2_pyro  out  XLEN  operand 2 or immediate.
- illegal_pyro  out  1  opcode not recognised.
- dec_valid_pyro  out  1  output bundle valid.
- dec_retry_pyri  in  1  downstream stall.
- busy_cnt_pyro  out  RA+1  number of busy bits set.

Behaviour:
- Reset (reset_pyri=0, async): scoreboard=0, regfile=0, dec_valid_pyro=0, all data outputs 0, busy_cnt_pyro=0.
- Handshake: a transfer occurs when valid=1 and retry=0. Retry may be raised with valid low.
- Output register free: free = !dec_valid_pyro || !dec_retry_pyri.
- Hazard: any required source busy, or destination busy when the op writes rd.
- inst_retry_pyro = inst_valid_pyri && (hazard || !free).
- On accept, the bundle is loaded and dec_valid_pyro=1 next cycle. Otherwise dec_valid_pyro clears when the held bundle is taken. Outputs are held stable while dec_valid_pyro && dec_retry_pyri.
- Op classes (opcode[6:0]):
  - ARITH 0110011 / ARITH_W 0111011: rs1, rs2; sets rd busy.
  - BRANCH 1100011 / STORE 0100011: rs1, rs2; no rd.
  - ARITH_I 0010011 / ARITH_W_I 0011011 / LOAD 0000011: rs1; src2 = sign-extended inst[31:20] to XLEN; sets rd busy.
  - JALR 1100111: rs1; sets rd busy.
  - JAL 1101111: no sources; sets rd busy.
  - LUI 0110111 / AUIPC 0010111: src1 = sign-extended inst[31:12] to XLEN; sets rd busy.
  - SYSTEM 1110011: issues only when the scoreboard is all-zero (busy_cnt_pyro==0), otherwise hazard.
  - Any other opcode: issues immediately with illegal_pyro=1 and no scoreboard change.
- Unused src outputs are 0.
- x0: always reads 0, never busy. Writes to x0 are ignored.
- Write-back:
  - Each valid port writes the regfile and clears the busy bit at the clock edge.
  - Two ports to the same address: the highest index wins the data.
- Scoreboard update order per cycle: clear by write-back, then set by accepted issue. Same-cycle clear and set of one register leaves it busy.
- Busy-bit clear for a non-busy register is harmless.
- busy_cnt_pyro reflects the registered scoreboard.

Optional Feature:
- PYRM_DECODE_BYPASS_EN defined:
  - Hazard checks use the scoreboard after write-back clears.
  - Source operands take same-cycle wb_data_pyri on an address match (highest port wins) instead of regfile data.
  - Zero-bubble issue when a dependency retires in the same cycle.
- Undefined:
  - Hazard checks use the registered scoreboard only.
  - The dependent instruction stalls one extra cycle and reads the regfile the next cycle.

Test Plan:
1. Reset, then write-back x5=0x1234 on port0. Next cycle issue ADD x7,x5,x0 (0x000283B3) → dec_valid_pyro=1 the cycle after, src1=0x1234, src2=0, busy_cnt=1.
2. Issue ADDI x6,x0,-1 → src2=0xFFFF_FFFF_FFFF_FFFF. Then ADD x8,x6,x6 → inst_retry_pyro=1 until wb x6. With BYPASS_EN, issue is the same cycle as wb, with src1=src2=wb data. Without it, issue is one cycle later.
3. dec_retry_pyri held high 3 cycles while a second instruction is valid → inst_retry_pyro=1, output bundle unchanged. Release → second bundle appears the next cycle.
4. Port0 and port1 both write x9 (0xA, 0xB) in the same cycle → later read of x9 = 0xB, x9 busy bit cleared.
5. ECALL (0x00000073) with x7 busy → stalls until x7 written back, then issues. Opcode 0x7F → illegal_pyro=1.
6. Assert reset_pyri low mid-stall with busy_cnt=3 → dec_valid_pyro, busy_cnt_pyro go 0 immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pyrm_decode_sb.sv
// pyrm_decode_sb: RISC-V decode/register-read stage with regfile, busy-bit scoreboard and NWB write-back ports.
// Optional macro PYRM_DECODE_BYPASS_EN: same-cycle write-back forwarding into hazard checks and operands.
module pyrm_decode_sb #(
   parameter int XLEN = 64,
   parameter int NREG = 32,
   parameter int NWB  = 2,
   localparam int RA  = $clog2(NREG)
) (
   input  logic              clk,
   input  logic              reset_pyri,
   input  logic [31:0]       inst_pyri,
   input  logic [XLEN-1:0]   pc_pyri,
   input  logic              inst_valid_pyri,
   output logic              inst_retry_pyro,
   input  logic [NWB-1:0]    wb_valid_pyri,
   input  logic [NWB*RA-1:0] wb_addr_pyri,
   input  logic [NWB*XLEN-1:0] wb_data_pyri,
   output logic [31:0]       inst_pyro,
   output logic [XLEN-1:0]   pc_pyro,
   output logic [XLEN-1:0]   src1_pyro,
   output logic [XLEN-1:0]   src2_pyro,
   output logic              illegal_pyro,
   output logic              dec_valid_pyro,
   input  logic              dec_retry_pyri,
   output logic [RA:0]       busy_cnt_pyro
);
   localparam int CW = RA + 1;

   logic [XLEN-1:0] rf [NREG];
   logic [NREG-1:0] sb, sb_eff, wb_clr, sb_set;
   logic [RA-1:0]   rd, rs1, rs2;
   logic [XLEN-1:0] rd1, rd2, src1, src2;
   logic            use1, use2, wrd, imm_i, imm_u, sys, ill;
   logic            hazard, free, accept;

   assign rd  = inst_pyri[7 +: RA];
   assign rs1 = inst_pyri[15 +: RA];
   assign rs2 = inst_pyri[20 +: RA];

   // Classify the opcode into source usage, destination write and immediate form.
   always_comb begin
      use1 = 1'b0;
      use2 = 1'b0;
      wrd = 1'b0;
      imm_i = 1'b0;
      imm_u = 1'b0;
      sys = 1'b0;
      ill = 1'b0;
      case (inst_pyri[6:0])
         7'b0110011, 7'b0111011: begin use1 = 1'b1; use2 = 1'b1; wrd = 1'b1; end
         7'b1100011, 7'b0100011: begin use1 = 1'b1; use2 = 1'b1; end
         7'b0010011, 7'b0011011, 7'b0000011: begin use1 = 1'b1; imm_i = 1'b1; wrd = 1'b1; end
         7'b1100111: begin use1 = 1'b1; wrd = 1'b1; end
         7'b1101111: wrd = 1'b1;
         7'b0110111, 7'b0010111: begin imm_u = 1'b1; wrd = 1'b1; end
         7'b1110011: sys = 1'b1;
         default: ill = 1'b1;
      endcase
   end

   // Registers retiring this cycle; x0 never holds a busy bit.
   always_comb begin
      wb_clr = '0;
      for (int k = 0; k < NWB; k++)
         if (wb_valid_pyri[k]) wb_clr[wb_addr_pyri[k*RA +: RA]] = 1'b1;
      wb_clr[0] = 1'b0;
   end

`ifdef PYRM_DECODE_BYPASS_EN
   assign sb_eff = sb & ~wb_clr;
`else
   assign sb_eff = sb;
`endif

   // Operand read; with forwarding the highest-index matching write-back port overrides the regfile.
   always_comb begin
      rd1 = rf[rs1];
      rd2 = rf[rs2];
`ifdef PYRM_DECODE_BYPASS_EN
      for (int k = 0; k < NWB; k++) begin
         if (wb_valid_pyri[k] && wb_addr_pyri[k*RA +: RA] == rs1) rd1 = wb_data_pyri[k*XLEN +: XLEN];
         if (wb_valid_pyri[k] && wb_addr_pyri[k*RA +: RA] == rs2) rd2 = wb_data_pyri[k*XLEN +: XLEN];
      end
`endif
      if (rs1 == '0) rd1 = '0;
      if (rs2 == '0) rd2 = '0;
   end

   assign src1 = use1 ? rd1 : imm_u ? {{(XLEN-20){inst_pyri[31]}}, inst_pyri[31:12]} : '0;
   assign src2 = use2 ? rd2 : imm_i ? {{(XLEN-12){inst_pyri[31]}}, inst_pyri[31:20]} : '0;

   assign hazard = (use1 && sb_eff[rs1]) || (use2 && sb_eff[rs2]) || (wrd && sb_eff[rd]) || (sys && |sb_eff);
   assign free = !dec_valid_pyro || !dec_retry_pyri;
   assign accept = inst_valid_pyri && !hazard && free;
   assign inst_retry_pyro = inst_valid_pyri && (hazard || !free);
   assign sb_set = (accept && wrd && rd != '0) ? (NREG'(1) << rd) : '0;

   // Scoreboard: retiring registers clear first, then the newly issued destination is marked busy.
   always_ff @(posedge clk or negedge reset_pyri) begin
      if (!reset_pyri) sb <= '0;
      else sb <= (sb & ~wb_clr) | sb_set;
   end

   // Register file writes; later ports overwrite earlier ones on the same address, x0 stays zero.
   always_ff @(posedge clk or negedge reset_pyri) begin
      if (!reset_pyri) begin
         for (int i = 0; i < NREG; i++) rf[i] <= '0;
      end else begin
         for (int k = 0; k < NWB; k++)
            if (wb_valid_pyri[k] && wb_addr_pyri[k*RA +: RA] != '0)
               rf[wb_addr_pyri[k*RA +: RA]] <= wb_data_pyri[k*XLEN +: XLEN];
      end
   end

   // Output bundle: load on accept, drop valid once taken, hold everything while stalled.
   always_ff @(posedge clk or negedge reset_pyri) begin
      if (!reset_pyri) begin
         dec_valid_pyro <= 1'b0;
         inst_pyro <= '0;
         pc_pyro <= '0;
         src1_pyro <= '0;
         src2_pyro <= '0;
         illegal_pyro <= 1'b0;
      end else if (accept) begin
         dec_valid_pyro <= 1'b1;
         inst_pyro <= inst_pyri;
         pc_pyro <= pc_pyri;
         src1_pyro <= src1;
         src2_pyro <= src2;
         illegal_pyro <= ill;
      end else if (free) begin
         dec_valid_pyro <= 1'b0;
      end
   end

   // Population count of the registered scoreboard.
   always_comb begin
      busy_cnt_pyro = '0;
      for (int i = 0; i < NREG; i++) busy_cnt_pyro = busy_cnt_pyro + CW'(sb[i]);
   end
endmodule

// File: tb/tb_pyrm_decode_sb.sv
// tb_pyrm_decode_sb: randomized and directed scoreboard bench for pyrm_decode_sb (honours PYRM_DECODE_BYPASS_EN).
module tb_pyrm_decode_sb;
   localparam int XLEN = 64, NREG = 32, NWB = 2, RA = 5;

   logic              clk = 1'b0;
   logic              reset_pyri = 1'b0;
   logic [31:0]       inst_pyri = '0;
   logic [XLEN-1:0]   pc_pyri = '0;
   logic              inst_valid_pyri = 1'b0;
   logic              inst_retry_pyro;
   logic [NWB-1:0]    wb_valid_pyri = '0;
   logic [NWB*RA-1:0] wb_addr_pyri = '0;
   logic [NWB*XLEN-1:0] wb_data_pyri = '0;
   logic [31:0]       inst_pyro;
   logic [XLEN-1:0]   pc_pyro, src1_pyro, src2_pyro;
   logic              illegal_pyro, dec_valid_pyro;
   logic              dec_retry_pyri = 1'b0;
   logic [RA:0]       busy_cnt_pyro;

   pyrm_decode_sb #(.XLEN(XLEN), .NREG(NREG), .NWB(NWB)) dut (
      .clk(clk), .reset_pyri(reset_pyri), .inst_pyri(inst_pyri), .pc_pyri(pc_pyri),
      .inst_valid_pyri(inst_valid_pyri), .inst_retry_pyro(inst_retry_pyro),
      .wb_valid_pyri(wb_valid_pyri), .wb_addr_pyri(wb_addr_pyri), .wb_data_pyri(wb_data_pyri),
      .inst_pyro(inst_pyro), .pc_pyro(pc_pyro), .src1_pyro(src1_pyro), .src2_pyro(src2_pyro),
      .illegal_pyro(illegal_pyro), .dec_valid_pyro(dec_valid_pyro), .dec_retry_pyri(dec_retry_pyri),
      .busy_cnt_pyro(busy_cnt_pyro)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]     inst;
      logic [XLEN-1:0] pc, s1, s2;
      logic            ill;
   } bnd_t;

   bnd_t            q[$];
   logic [XLEN-1:0] mrf [NREG];
   logic            mb [NREG];
   logic            m_full, m_acc;
   int              checks = 0, errors = 0;
   logic [6:0]      ops [14] = '{7'h33, 7'h3B, 7'h63, 7'h23, 7'h13, 7'h1B, 7'h03,
                                 7'h67, 7'h6F, 7'h37, 7'h17, 7'h73, 7'h7F, 7'h0F};

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic model_reset();
      for (int r = 0; r < NREG; r++) begin
         mrf[r] = '0;
         mb[r] = 1'b0;
      end
      m_full = 1'b0;
      m_acc = 1'b0;
      q.delete();
   endtask

   function automatic logic retiring(input int r);
      logic hit = 1'b0;
      for (int k = 0; k < NWB; k++)
         if (wb_valid_pyri[k] && int'(wb_addr_pyri[k*RA +: RA]) == r) hit = 1'b1;
      return hit;
   endfunction

   function automatic logic busy(input int r);
`ifdef PYRM_DECODE_BYPASS_EN
      return r != 0 && mb[r] && !retiring(r);
`else
      return r != 0 && mb[r];
`endif
   endfunction

   function automatic logic [XLEN-1:0] rval(input int r);
      logic [XLEN-1:0] v = mrf[r];
`ifdef PYRM_DECODE_BYPASS_EN
      for (int k = 0; k < NWB; k++)
         if (wb_valid_pyri[k] && int'(wb_addr_pyri[k*RA +: RA]) == r) v = wb_data_pyri[k*XLEN +: XLEN];
`endif
      return r == 0 ? '0 : v;
   endfunction

   // Per cycle: predict the handshake at the negedge, then advance the model at the posedge.
   task automatic cycle();
      logic u1, u2, w, ii, iu, sy, il, hz;
      int   rd, r1, r2, cnt;
      bnd_t b;
      @(negedge clk);
      {u1, u2, w, ii, iu, sy, il} = '0;
      case (inst_pyri[6:0])
         7'h33, 7'h3B: {u1, u2, w} = 3'b111;
         7'h63, 7'h23: {u1, u2} = 2'b11;
         7'h13, 7'h1B, 7'h03: {u1, ii, w} = 3'b111;
         7'h67: {u1, w} = 2'b11;
         7'h6F: w = 1'b1;
         7'h37, 7'h17: {iu, w} = 2'b11;
         7'h73: sy = 1'b1;
         default: il = 1'b1;
      endcase
      rd = int'(inst_pyri[11:7]);
      r1 = int'(inst_pyri[19:15]);
      r2 = int'(inst_pyri[24:20]);
      hz = (u1 && busy(r1)) || (u2 && busy(r2)) || (w && busy(rd));
      if (sy) for (int r = 1; r < NREG; r++) if (busy(r)) hz = 1'b1;
      m_acc = inst_valid_pyri && !hz && (!m_full || !dec_retry_pyri);
      chk("inst_retry", 64'(inst_retry_pyro), 64'(inst_valid_pyri && !m_acc));
      cnt = 0;
      for (int r = 0; r < NREG; r++) if (mb[r]) cnt++;
      chk("busy_cnt", 64'(busy_cnt_pyro), 64'(cnt));
      chk("dec_valid", 64'(dec_valid_pyro), 64'(m_full));
      if (m_acc) begin
         b.inst = inst_pyri;
         b.pc = pc_pyri;
         b.ill = il;
         b.s1 = u1 ? rval(r1) : iu ? {{(XLEN-20){inst_pyri[31]}}, inst_pyri[31:12]} : '0;
         b.s2 = u2 ? rval(r2) : ii ? {{(XLEN-12){inst_pyri[31]}}, inst_pyri[31:20]} : '0;
         q.push_back(b);
      end
      @(posedge clk);
      for (int k = 0; k < NWB; k++)
         if (wb_valid_pyri[k] && wb_addr_pyri[k*RA +: RA] != '0) begin
            mrf[wb_addr_pyri[k*RA +: RA]] = wb_data_pyri[k*XLEN +: XLEN];
            mb[wb_addr_pyri[k*RA +: RA]] = 1'b0;
         end
      if (m_acc && w && rd != 0) mb[rd] = 1'b1;
      m_full = m_acc || (m_full && dec_retry_pyri);
      #1;
   endtask

   task automatic drive(input logic iv, input logic [31:0] in, input logic [1:0] wv,
                        input logic [4:0] a0, input logic [63:0] d0,
                        input logic [4:0] a1, input logic [63:0] d1, input logic dr);
      inst_valid_pyri = iv;
      inst_pyri = in;
      pc_pyri = {$urandom, $urandom};
      wb_valid_pyri = wv;
      wb_addr_pyri = {a1, a0};
      wb_data_pyri = {d1, d0};
      dec_retry_pyri = dr;
      cycle();
   endtask

   // Monitor: every bundle taken downstream must match the oldest expected one.
   initial begin
      bnd_t b;
      forever begin
         @(negedge clk);
         if (reset_pyri && dec_valid_pyro && !dec_retry_pyri) begin
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL out_unexpected: got inst %h expected no bundle", inst_pyro);
            end else begin
               b = q.pop_front();
               chk("out_inst", 64'(inst_pyro), 64'(b.inst));
               chk("out_pc", pc_pyro, b.pc);
               chk("out_src1", src1_pyro, b.s1);
               chk("out_src2", src2_pyro, b.s2);
               chk("out_illegal", 64'(illegal_pyro), 64'(b.ill));
            end
         end
      end
   end

   initial begin
      logic [31:0] in;
      model_reset();
      #2;
      chk("rst_dec_valid", 64'(dec_valid_pyro), 0);
      chk("rst_busy_cnt", 64'(busy_cnt_pyro), 0);
      chk("rst_src1", src1_pyro, 0);
      chk("rst_src2", src2_pyro, 0);
      chk("rst_inst", 64'(inst_pyro), 0);
      chk("rst_pc", pc_pyro, 0);
      chk("rst_illegal", 64'(illegal_pyro), 0);
      #10 reset_pyri = 1'b1;
      @(posedge clk);
      #1;
      // write x5, then ADD x7,x5,x0
      drive(0, 0, 2'b01, 5, 64'h1234, 0, 0, 0);
      drive(1, 32'h000283B3, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      // ADDI x6,x0,-1 then dependent ADD x8,x6,x6
      drive(1, 32'hFFF00313, 0, 0, 0, 0, 0, 0);
      repeat (3) drive(1, 32'h00630433, 0, 0, 0, 0, 0, 0);
      drive(1, 32'h00630433, 2'b01, 6, 64'hABCD_0000_1111_2222, 0, 0, 0);
      drive(1, 32'h00630433, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      // downstream stall with a second instruction waiting
      drive(1, 32'h00500593, 0, 0, 0, 0, 0, 0);
      repeat (3) drive(1, 32'h00700613, 0, 0, 0, 0, 0, 1);
      drive(1, 32'h00700613, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      // both ports write x9 together, then read it back
      drive(1, 32'h00000493, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 2'b11, 9, 64'hA, 9, 64'hB, 0);
      drive(1, 32'h00048533, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      // retire everything except x7, then ECALL waits on x7
      for (int r = 1; r < NREG; r++)
         if (r != 7) drive(0, 0, 2'b01, 5'(r), 64'(r), 0, 0, 0);
      repeat (3) drive(1, 32'h00000073, 0, 0, 0, 0, 0, 0);
      drive(1, 32'h00000073, 2'b10, 0, 0, 7, 64'h77, 0);
      drive(1, 32'h00000073, 0, 0, 0, 0, 0, 0);
      drive(1, 32'h0000007F, 0, 0, 0, 0, 0, 0);
      drive(0, 0, 0, 0, 0, 0, 0, 0);
      // randomized traffic
      for (int n = 0; n < 500; n++) begin
         in = $urandom;
         in[6:0] = ops[$urandom_range(0, 13)];
         in[11:7] = 5'($urandom_range(0, 7));
         in[19:15] = 5'($urandom_range(0, 7));
         in[24:20] = 5'($urandom_range(0, 7));
         drive($urandom_range(0, 3) != 0, in,
               {$urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0},
               5'($urandom_range(0, 7)), {$urandom, $urandom},
               5'($urandom_range(0, 7)), {$urandom, $urandom},
               $urandom_range(0, 3) == 0);
      end
      repeat (3) drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("queue_drained", 64'(q.size()), 0);
      // three busy registers, dependent instruction stalled, then asynchronous reset
      for (int r = 1; r < NREG; r++) drive(0, 0, 2'b01, 5'(r), 64'(r), 0, 0, 0);
      drive(1, 32'h00100093, 0, 0, 0, 0, 0, 0);
      drive(1, 32'h00100113, 0, 0, 0, 0, 0, 0);
      drive(1, 32'h00100193, 0, 0, 0, 0, 0, 0);
      repeat (2) drive(1, 32'h00008233, 0, 0, 0, 0, 0, 0);
      chk("pre_rst_busy_cnt", 64'(busy_cnt_pyro), 3);
      #2 reset_pyri = 1'b0;
      #1;
      chk("async_rst_dec_valid", 64'(dec_valid_pyro), 0);
      chk("async_rst_busy_cnt", 64'(busy_cnt_pyro), 0);
      chk("async_rst_src1", src1_pyro, 0);
      model_reset();
      inst_valid_pyri = 1'b0;
      wb_valid_pyri = '0;
      @(negedge clk);
      #1 reset_pyri = 1'b1;
      @(posedge clk);
      #1;
      drive(1, 32'h00008233, 0, 0, 0, 0, 0, 0);
      repeat (2) drive(0, 0, 0, 0, 0, 0, 0, 0);
      chk("final_queue_drained", 64'(q.size()), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
